// File: rtl/sensor_limiar_pkg.sv
// Shared definitions for the threshold/hysteresis stage: state encoding and defaults.
// The encoding matches the one used by the downstream controller.
package sensor_limiar_pkg;

    localparam int W_DEF      = 8;
    localparam int HIST_DEF   = 2;
    localparam int N_CONF_DEF = 3;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_BAIXO  = 2'b01,
        ST_ALTO   = 2'b10
    } estado_t;

    // Returns {high, low} for a given state; never both set.
    function automatic logic [1:0] flags_estado(input estado_t e);
        logic [1:0] f;
        case (e)
            ST_BAIXO: f = 2'b01;
            ST_ALTO:  f = 2'b10;
            default:  f = 2'b00;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sensor_limiar_if.sv
// Sample stream, thresholds and decision flags between a sensor front end and sensor_limiar.
interface sensor_limiar_if #(
    parameter int W = 8
);
    logic         amostra_valida;
    logic [W-1:0] amostra;
    logic [W-1:0] lim_inf;
    logic [W-1:0] lim_sup;
    logic         low_out;
    logic         high_out;
    logic         nova_decisao;
    logic         erro_cfg;

    modport master (
        output amostra_valida, amostra, lim_inf, lim_sup,
        input  low_out, high_out, nova_decisao, erro_cfg
    );

    modport slave (
        input  amostra_valida, amostra, lim_inf, lim_sup,
        output low_out, high_out, nova_decisao, erro_cfg
    );
endinterface

// File: rtl/sensor_limiar_contador.sv
// Confirmation counter: counts agreeing samples and flags the one that reaches N_CONF.
// clr+inc together restarts the count at 1; reaching N_CONF self-clears the count.
module contador_confirmacao #(
    parameter int CNT_W  = 2,
    parameter int N_CONF = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             atingiu
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] prox_s;

    // Next count from the clear/increment controls.
    always_comb begin
        prox_s = cnt_r;
        if (clr && inc) begin
            prox_s = CNT_W'(1);
        end else if (clr) begin
            prox_s = {CNT_W{1'b0}};
        end else if (inc) begin
            prox_s = cnt_r + CNT_W'(1);
        end else begin
            prox_s = cnt_r;
        end
    end

    assign atingiu = inc && (prox_s == CNT_W'(N_CONF));
    assign cnt     = cnt_r;

    // Count register; returns to zero once the target count is hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (atingiu) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= prox_s;
        end
    end

endmodule

// File: rtl/sensor_limiar.sv
// Converts a raw sensor sample stream into registered low/high flags with
// thresholds, saturating hysteresis bounds and N-sample confirmation.
module sensor_limiar
    import sensor_limiar_pkg::*;
#(
    parameter  int W      = W_DEF,
    parameter  int HIST   = HIST_DEF,
    parameter  int N_CONF = N_CONF_DEF,
    localparam int CNT_W  = $clog2(N_CONF + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sensor_limiar_if.slave   bus
);

    estado_t          state_r;
    estado_t          state_next_s;
    estado_t          cand_r;
    estado_t          cand_next_s;
    estado_t          tgt_s;
    logic [W:0]       sub_lim_ext_s;
    logic [W:0]       des_lim_ext_s;
    logic [W-1:0]     sub_lim_s;
    logic [W-1:0]     des_lim_s;
    logic             err_s;
    logic             clr_s;
    logic             inc_s;
    logic             atingiu_s;
    logic             reinicia_s;
    logic [CNT_W-1:0] cnt_s;
    logic             low_r;
    logic             high_r;
    logic             nova_r;
    logic             erro_r;

    assign err_s = (bus.lim_inf >= bus.lim_sup);

    // Exit bounds in W+1 bits, clamped to the representable range.
    always_comb begin
        sub_lim_ext_s = {1'b0, bus.lim_inf} + (W+1)'(HIST);
        des_lim_ext_s = {1'b0, bus.lim_sup} - (W+1)'(HIST);
        if (sub_lim_ext_s[W]) begin
            sub_lim_s = {W{1'b1}};
        end else begin
            sub_lim_s = sub_lim_ext_s[W-1:0];
        end
        if (des_lim_ext_s[W]) begin
            des_lim_s = {W{1'b0}};
        end else begin
            des_lim_s = des_lim_ext_s[W-1:0];
        end
    end

    // Target state of the current sample, relative to the present state.
    always_comb begin
        tgt_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (bus.amostra < bus.lim_inf) begin
                    tgt_s = ST_BAIXO;
                end else if (bus.amostra > bus.lim_sup) begin
                    tgt_s = ST_ALTO;
                end else begin
                    tgt_s = ST_NORMAL;
                end
            end
            ST_BAIXO: begin
                if (bus.amostra > bus.lim_sup) begin
                    tgt_s = ST_ALTO;
                end else if (bus.amostra >= sub_lim_s) begin
                    tgt_s = ST_NORMAL;
                end else begin
                    tgt_s = ST_BAIXO;
                end
            end
            ST_ALTO: begin
                if (bus.amostra < bus.lim_inf) begin
                    tgt_s = ST_BAIXO;
                end else if (bus.amostra <= des_lim_s) begin
                    tgt_s = ST_NORMAL;
                end else begin
                    tgt_s = ST_ALTO;
                end
            end
            default: tgt_s = ST_NORMAL;
        endcase
    end

    // With an empty count the stored candidate is stale, so any target restarts at 1.
    assign reinicia_s = (tgt_s != cand_r) || (cnt_s == {CNT_W{1'b0}});

    // Counter control and candidate tracking.
    always_comb begin
        clr_s       = 1'b0;
        inc_s       = 1'b0;
        cand_next_s = cand_r;
        if (err_s) begin
            clr_s       = 1'b1;
            cand_next_s = ST_NORMAL;
        end else if (bus.amostra_valida) begin
            if (tgt_s == state_r) begin
                clr_s = 1'b1;
            end else if (reinicia_s) begin
                clr_s       = 1'b1;
                inc_s       = 1'b1;
                cand_next_s = tgt_s;
            end else begin
                inc_s = 1'b1;
            end
        end else begin
            clr_s = 1'b0;
        end
    end

    contador_confirmacao #(
        .CNT_W  (CNT_W),
        .N_CONF (N_CONF)
    ) u_contador (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .inc     (inc_s),
        .cnt     (cnt_s),
        .atingiu (atingiu_s)
    );

    // Next state: a bad configuration forces NORMAL, otherwise switch on confirmation.
    always_comb begin
        state_next_s = state_r;
        if (err_s) begin
            state_next_s = ST_NORMAL;
        end else if (atingiu_s) begin
            state_next_s = tgt_s;
        end else begin
            state_next_s = state_r;
        end
    end

    // State, candidate and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_NORMAL;
            cand_r  <= ST_NORMAL;
            low_r   <= 1'b0;
            high_r  <= 1'b0;
            nova_r  <= 1'b0;
            erro_r  <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            cand_r            <= cand_next_s;
            {high_r, low_r}   <= flags_estado(state_next_s);
            nova_r            <= (state_next_s != state_r);
            erro_r            <= err_s;
        end
    end

    assign bus.low_out      = low_r;
    assign bus.high_out     = high_r;
    assign bus.nova_decisao = nova_r;
    assign bus.erro_cfg     = erro_r;

endmodule

// File: tb/tb_sensor_limiar.sv
// Directed bench for sensor_limiar (W=8, HIST=2, N_CONF=3) with hand-computed expectations.
module tb_sensor_limiar;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    sensor_limiar_if #(.W(8)) bus ();

    sensor_limiar #(.W(8), .HIST(2), .N_CONF(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; returns just after the edge that sampled it.
    task automatic send(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.amostra_valida = 1'b1;
            bus.amostra        = v;
            tick();
            bus.amostra_valida = 1'b0;
        end
    endtask

    task automatic flags(input string tag, input logic lo, input logic hi, input logic nv);
        check_eq({tag, "_low"},  {31'd0, bus.low_out},      {31'd0, lo});
        check_eq({tag, "_high"}, {31'd0, bus.high_out},     {31'd0, hi});
        check_eq({tag, "_nova"}, {31'd0, bus.nova_decisao}, {31'd0, nv});
    endtask

    task automatic set_lims(input logic [7:0] li, input logic [7:0] ls);
        bus.lim_inf = li;
        bus.lim_sup = ls;
    endtask

    initial begin
        rst                = 1'b1;
        bus.amostra_valida = 1'b0;
        bus.amostra        = 8'd0;
        set_lims(8'd40, 8'd60);
        repeat (2) @(posedge clk);
        #1;
        flags("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset_erro", {31'd0, bus.erro_cfg}, 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Three agreeing low samples enter BAIXO
        send(8'd35, 2);
        flags("low_pend", 1'b0, 1'b0, 1'b0);
        send(8'd35, 1);
        flags("low_in", 1'b1, 1'b0, 1'b1);
        tick();
        flags("low_hold", 1'b1, 1'b0, 1'b0);

        // Hysteresis inside BAIXO
        send(8'd41, 5);
        flags("hist_41", 1'b1, 1'b0, 1'b0);
        send(8'd42, 2);
        flags("hist_42_pend", 1'b1, 1'b0, 1'b0);
        send(8'd42, 1);
        flags("hist_42_exit", 1'b0, 1'b0, 1'b1);

        // Interrupted run does not confirm
        send(8'd35, 2);
        send(8'd50, 1);
        send(8'd35, 2);
        flags("interrupt", 1'b0, 1'b0, 1'b0);

        // Reset discards a pending count of 2
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        tick();
        send(8'd35, 1);
        flags("discard", 1'b0, 1'b0, 1'b0);
        send(8'd35, 2);
        flags("low_again", 1'b1, 1'b0, 1'b1);

        // Reset mid-run with low_out set and two strobes pending
        send(8'd70, 2);
        flags("alto_pend", 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        flags("rst_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        send(8'd35, 2);
        flags("after_rst", 1'b0, 1'b0, 1'b0);
        send(8'd35, 1);
        flags("low_3rd", 1'b1, 1'b0, 1'b1);

        // Direct BAIXO->ALTO and ALTO->BAIXO
        send(8'd70, 3);
        flags("b2a", 1'b0, 1'b1, 1'b1);
        send(8'd10, 2);
        flags("a2b_pend", 1'b0, 1'b1, 1'b0);
        send(8'd10, 1);
        flags("a2b", 1'b1, 1'b0, 1'b1);
        tick();
        flags("a2b_hold", 1'b1, 1'b0, 1'b0);
        send(8'd70, 3);
        flags("alto", 1'b0, 1'b1, 1'b1);

        // Inverted limits force NORMAL and ignore samples
        set_lims(8'd60, 8'd40);
        tick();
        check_eq("cfg_erro", {31'd0, bus.erro_cfg}, 32'd1);
        flags("cfg_force", 1'b0, 1'b0, 1'b1);
        tick();
        flags("cfg_hold", 1'b0, 1'b0, 1'b0);
        send(8'd70, 3);
        flags("cfg_ign_hi", 1'b0, 1'b0, 1'b0);
        send(8'd10, 3);
        flags("cfg_ign_lo", 1'b0, 1'b0, 1'b0);
        set_lims(8'd40, 8'd60);
        tick();
        check_eq("cfg_clear", {31'd0, bus.erro_cfg}, 32'd0);
        send(8'd70, 2);
        flags("cfg_restart", 1'b0, 1'b0, 1'b0);
        send(8'd70, 1);
        flags("cfg_alto", 1'b0, 1'b1, 1'b1);

        // Upper saturation of the BAIXO exit bound
        set_lims(8'd254, 8'd255);
        tick();
        check_eq("sat_hi_erro", {31'd0, bus.erro_cfg}, 32'd0);
        send(8'd10, 3);
        flags("sat_hi_baixo", 1'b1, 1'b0, 1'b1);
        send(8'd254, 3);
        flags("sat_hi_254", 1'b1, 1'b0, 1'b0);
        send(8'd255, 3);
        flags("sat_hi_255", 1'b0, 1'b0, 1'b1);

        // Lower saturation of the ALTO exit bound
        set_lims(8'd0, 8'd1);
        tick();
        check_eq("sat_lo_erro", {31'd0, bus.erro_cfg}, 32'd0);
        send(8'd200, 3);
        flags("sat_lo_alto", 1'b0, 1'b1, 1'b1);
        send(8'd1, 3);
        flags("sat_lo_1", 1'b0, 1'b1, 1'b0);
        send(8'd0, 3);
        flags("sat_lo_0", 1'b0, 1'b0, 1'b1);

        // Equal limits count as a configuration error
        set_lims(8'd40, 8'd40);
        tick();
        check_eq("cfg_equal", {31'd0, bus.erro_cfg}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
